// File: rtl/timer_if.sv
// Register bus between the core and the timer slave (rom/ram slave contract),
// plus the interrupt line back to the core.
interface timer_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_sig_o;

    modport master (
        output we_i,
        output addr_i,
        output data_i,
        input  data_o,
        input  int_sig_o
    );

    modport slave (
        input  we_i,
        input  addr_i,
        input  data_i,
        output data_o,
        output int_sig_o
    );
endinterface

// File: rtl/timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter with compare/wrap, a sticky
// pending flag and an interrupt output gated by IE.
module timer #(
    parameter int unsigned PRESCALE = 1
) (
    input logic     clk,
    input logic     rst,
    timer_if.slave  bus
);

    localparam logic [15:0] PresLast = 16'(PRESCALE - 1);

    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        pend_q, pend_d;
    logic [31:0] count_q, count_d;
    logic [31:0] value_q, value_d;
    logic [15:0] presc_q, presc_d;

    logic wr_ctrl, wr_count, wr_value;
    logic tick, armed, wrap;

    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

    always_comb begin
        wr_ctrl  = bus.we_i && (bus.addr_i[3:2] == 2'd0);
        wr_count = bus.we_i && (bus.addr_i[3:2] == 2'd1);
        wr_value = bus.we_i && (bus.addr_i[3:2] == 2'd2);
        tick     = en_q && (presc_q == PresLast);
        armed    = (value_q != 32'd0);
        // value_q >= 1 here, so value_q - 1 cannot underflow
        wrap     = tick && armed && (count_q >= value_q - 32'd1);
    end

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        pend_d  = pend_q;
        count_d = count_q;
        value_d = value_q;
        presc_d = presc_q + 16'd1;

        if (!en_q || tick || (wr_ctrl && !bus.data_i[0])) begin
            presc_d = 16'd0;
        end

        if (wrap) begin
            count_d = 32'd0;
        end else if (tick && armed) begin
            count_d = count_q + 32'd1;
        end

        // Hardware set beats a simultaneous W1C.
        if (wrap) begin
            pend_d = 1'b1;
        end else if (wr_ctrl && bus.data_i[2]) begin
            pend_d = 1'b0;
        end

        if (wr_ctrl) begin
            en_d = bus.data_i[0];
            ie_d = bus.data_i[1];
        end
        // Software write to COUNT beats a same-cycle tick.
        if (wr_count) begin
            count_d = bus.data_i;
        end
        if (wr_value) begin
            value_d = bus.data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            count_q <= 32'd0;
            value_q <= 32'd0;
            presc_q <= 16'd0;
        end else begin
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            value_q <= value_d;
            presc_q <= presc_d;
        end
    end

    always_comb begin
        bus.data_o = 32'd0;
        case (bus.addr_i[3:2])
            2'd0:    bus.data_o = {29'd0, pend_q, ie_q, en_q};
            2'd1:    bus.data_o = count_q;
            2'd2:    bus.data_o = value_q;
            default: bus.data_o = 32'd0;
        endcase
    end

    assign bus.int_sig_o = pend_q & ie_q;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) share one stimulus stream and
// are compared against a behavioural model of the register map.
module tb_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    timer_if bus0 ();
    timer_if bus1 ();

    timer #(.PRESCALE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    timer #(.PRESCALE(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic        en;
        logic        ie;
        logic        pend;
        logic [31:0] count;
        logic [31:0] value;
        int unsigned run;    // cycles spent enabled since the last stop
    } mstate_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    mstate_t     m [2];
    int unsigned ps [2] = '{1, 4};
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    function automatic mstate_t mstep(mstate_t s, int unsigned p, logic we,
                                      logic [31:0] a, logic [31:0] d);
        mstate_t n = s;
        bit      tick, set;
        tick = s.en && ((s.run + 1) % p == 0);
        set  = 0;
        n.run = s.en ? s.run + 1 : 0;
        if (tick && s.value != 0) begin
            if ({1'b0, s.count} + 33'd1 >= {1'b0, s.value}) begin
                n.count = 0;
                set     = 1;
            end else begin
                n.count = s.count + 1;
            end
        end
        if (set) n.pend = 1;
        if (we) begin
            case (a[3:2])
                2'd0: begin
                    n.en = d[0];
                    n.ie = d[1];
                    if (d[2] && !set) n.pend = 0;
                    if (!d[0]) n.run = 0;
                end
                2'd1: n.count = d;
                2'd2: n.value = d;
                default: ;
            endcase
        end
        return n;
    endfunction

    function automatic logic [31:0] mread(mstate_t s, logic [31:0] a);
        case (a[3:2])
            2'd0:    return {29'd0, s.pend, s.ie, s.en};
            2'd1:    return s.count;
            2'd2:    return s.value;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.id == 0) begin
                check($sformatf("p1 rd @%08h", e.addr), bus0.data_o, e.rdata);
                check("p1 int", {31'd0, bus0.int_sig_o}, {31'd0, e.irq});
            end else begin
                check($sformatf("p4 rd @%08h", e.addr), bus1.data_o, e.rdata);
                check("p4 int", {31'd0, bus1.int_sig_o}, {31'd0, e.irq});
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus0.we_i = we; bus0.addr_i = a; bus0.data_i = d;
        bus1.we_i = we; bus1.addr_i = a; bus1.data_i = d;
    endtask

    // One bus cycle: starts just after a posedge, ends just after the next one.
    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
        drive(we, a, d);
        for (int k = 0; k < 2; k++)
            sb.push_back('{k, a, mread(m[k], a), m[k].pend & m[k].ie});
        @(posedge clk);
        for (int k = 0; k < 2; k++) m[k] = mstep(m[k], ps[k], we, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, ($urandom() & ~32'hC) | (32'($urandom_range(0, 3)) << 2), $urandom());
    endtask

    task automatic reset_check(input string tag);
        for (int k = 0; k < 2; k++) m[k] = '{default: '0};
        for (int off = 0; off < 4; off++) begin
            drive(1'b0, 32'(off) << 2, 32'hFFFF_FFFF);
            #1;
            check({tag, " p1 rd"}, bus0.data_o, 32'd0);
            check({tag, " p4 rd"}, bus1.data_o, 32'd0);
        end
        check({tag, " p1 int"}, {31'd0, bus0.int_sig_o}, 32'd0);
        check({tag, " p4 int"}, {31'd0, bus1.int_sig_o}, 32'd0);
    endtask

    task automatic wait_model(input int id, input logic [31:0] cnt, input string tag);
        int n = 0;
        while (!(m[id].count == cnt && m[id].en) && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL %s: timeout waiting for count %0d", tag, cnt);
        end
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0);
        #3;
        reset_check("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // Basic period and W1C
        cyc(1'b1, 32'h8, 32'd5);
        cyc(1'b1, 32'h0, 32'h3);
        repeat (12) cyc(1'b0, 32'h4, 32'd0);
        cyc(1'b1, 32'h0, 32'h7);
        repeat (2) cyc(1'b0, 32'h0, 32'd0);
        // W1C landing on a wrap of the PRESCALE=1 timer
        wait_model(0, 32'd4, "w1c_wrap");
        cyc(1'b1, 32'h0, 32'h7);
        repeat (3) cyc(1'b0, 32'h0, 32'd0);

        // Prescale, freeze and restart
        cyc(1'b1, 32'h0, 32'h4);
        cyc(1'b1, 32'h4, 32'd0);
        cyc(1'b1, 32'h8, 32'd3);
        cyc(1'b1, 32'h0, 32'h3);
        repeat (30) cyc(1'b0, 32'h4, 32'd0);
        cyc(1'b1, 32'h0, 32'h2);
        repeat (6) cyc(1'b0, 32'h4, 32'd0);
        cyc(1'b1, 32'h0, 32'h3);
        repeat (10) cyc(1'b0, 32'h4, 32'd0);

        // Disarmed timer, COUNT above VALUE, IE masking
        cyc(1'b1, 32'h0, 32'h4);
        cyc(1'b1, 32'h4, 32'd0);
        cyc(1'b1, 32'h8, 32'd0);
        cyc(1'b1, 32'h0, 32'h3);
        idle(100);
        cyc(1'b1, 32'h8, 32'd8);
        cyc(1'b1, 32'h4, 32'h10);
        repeat (6) cyc(1'b0, 32'h0, 32'd0);
        cyc(1'b1, 32'h0, 32'h1);
        repeat (3) cyc(1'b0, 32'h0, 32'd0);

        // Asynchronous reset in the middle of a cycle
        cyc(1'b1, 32'h0, 32'h3);
        idle(5);
        #1 rst = 1'b1;
        reset_check("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int off = 0; off < 4; off++) cyc(1'b0, 32'(off) << 2, 32'd0);

        // Bus decode and aliasing
        cyc(1'b1, 32'hC, 32'hFFFF_FFFF);
        cyc(1'b1, 32'h0, 32'hFFFF_FFFF);
        cyc(1'b0, 32'hC, 32'd0);
        cyc(1'b0, 32'h0, 32'd0);
        cyc(1'b1, 32'h1000_0004, 32'h7);
        cyc(1'b0, 32'h1000_0004, 32'd0);
        cyc(1'b0, 32'hFFFF_FFF4, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r = $urandom_range(0, 99);
            logic [31:0] hi = $urandom() & ~32'hC;
            if (r < 70)      idle(1);
            else if (r < 80) cyc(1'b1, hi, {$urandom(), 1'b0} | 32'($urandom_range(0, 7) | 1));
            else if (r < 83) cyc(1'b1, hi, 32'($urandom_range(0, 7)));
            else if (r < 90) cyc(1'b1, hi | 32'h4, 32'($urandom_range(0, 15)));
            else if (r < 96) cyc(1'b1, hi | 32'h8, 32'($urandom_range(0, 12)));
            else             cyc(1'b1, hi | 32'hC, $urandom());
        end

        drive(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
